// File: rtl/iic_target.sv
// I2C EEPROM-style target with 1/2-byte word addressing and a synchronous byte memory port.
// Optional build macro IIC_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda.
module iic_target #(
   parameter logic [6:0]  DEVICE_ADDR = 7'b1010000,
   parameter int unsigned MEM_AW      = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              bit_ctrl,
   input  logic              scl,
   inout  wire               sda,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              stop_det
);

   typedef enum logic [3:0] {
      StIdle, StDevAddr, StDevAck, StWord1, StWord1Ack, StWord2, StWord2Ack,
      StWrData, StWrAck, StRdData, StRdAck
   } state_e;

   logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q, scl_h_q, sda_h_q;
   logic scl_v, sda_v;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         scl_h_q  <= 1'b1;
         sda_h_q  <= 1'b1;
      end else begin
         scl_s1_q <= scl;
         scl_s2_q <= scl_s1_q;
         sda_s1_q <= sda;
         sda_s2_q <= sda_s1_q;
         scl_h_q  <= scl_v;
         sda_h_q  <= sda_v;
      end
   end

`ifdef IIC_TGT_GLITCH_FILTER_EN
   logic [1:0] scl_m_q, sda_m_q;
   logic       scl_f_q, sda_f_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         scl_m_q <= 2'b11;
         sda_m_q <= 2'b11;
         scl_f_q <= 1'b1;
         sda_f_q <= 1'b1;
      end else begin
         scl_m_q <= {scl_m_q[0], scl_s2_q};
         sda_m_q <= {sda_m_q[0], sda_s2_q};
         scl_f_q <= (scl_s2_q & scl_m_q[0]) | (scl_s2_q & scl_m_q[1]) | (scl_m_q[0] & scl_m_q[1]);
         sda_f_q <= (sda_s2_q & sda_m_q[0]) | (sda_s2_q & sda_m_q[1]) | (sda_m_q[0] & sda_m_q[1]);
      end
   end

   assign scl_v = scl_f_q;
   assign sda_v = sda_f_q;
`else
   assign scl_v = scl_s2_q;
   assign sda_v = sda_s2_q;
`endif

   logic scl_rise, scl_fall, start, stop;
   assign scl_rise = scl_v & ~scl_h_q;
   assign scl_fall = ~scl_v & scl_h_q;
   assign start    = scl_v & scl_h_q & sda_h_q & ~sda_v;
   assign stop     = scl_v & scl_h_q & ~sda_h_q & sda_v;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [7:0]        sr_q, sr_d, hi_q, hi_d;
   logic [MEM_AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, ack_ok_q, ack_ok_d;
   logic              we_q, we_d, re_q, re_d, stop_q, stop_d, rd_cap_q;

   logic [7:0]        byte_in, lo_inc;
   logic [MEM_AW-1:0] ptr_inc;
   assign byte_in = {sr_q[6:0], sda_v};
   assign lo_inc  = ptr_q[7:0] + 8'd1;
   assign ptr_inc = bit_ctrl ? ptr_q + {{(MEM_AW-1){1'b0}}, 1'b1} : MEM_AW'(lo_inc);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      hi_d     = hi_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rw_d     = rw_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      ack_ok_d = ack_ok_q;
      we_d     = 1'b0;
      re_d     = 1'b0;
      stop_d   = 1'b0;
      // Read data arrives the cycle after mem_re; load it before the next falling edge.
      if (rd_cap_q) sr_d = mem_rdata;

      if (stop) begin
         state_d = StIdle;
         oe_d    = 1'b0;
         stop_d  = 1'b1;
         busy_d  = 1'b0;
      end else if (start) begin
         state_d = StDevAddr;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            StDevAddr, StWord1, StWord2, StWrData: begin
               if (scl_rise && !cnt_q[3]) begin
                  sr_d  = byte_in;
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     case (state_q)
                        StDevAddr: begin
                           if (sr_q[6:0] != DEVICE_ADDR) state_d = StIdle;
                           rw_d = sda_v;
                        end
                        StWord1: begin
                           if (bit_ctrl) hi_d = byte_in;
                           else          ptr_d = MEM_AW'(byte_in);
                        end
                        StWord2: ptr_d = MEM_AW'({hi_q, byte_in});
                        default: begin
                           we_d    = 1'b1;
                           addr_d  = ptr_q;
                           wdata_d = byte_in;
                           ptr_d   = ptr_inc;
                        end
                     endcase
                  end
               end else if (scl_fall && cnt_q[3]) begin
                  oe_d = 1'b1;
                  case (state_q)
                     StDevAddr: begin
                        busy_d  = 1'b1;
                        state_d = StDevAck;
                     end
                     StWord1: state_d = StWord1Ack;
                     StWord2: state_d = StWord2Ack;
                     default: state_d = StWrAck;
                  endcase
               end
            end
            StDevAck: begin
               if (scl_rise && rw_q) begin
                  re_d   = 1'b1;
                  addr_d = ptr_q;
               end else if (scl_fall) begin
                  cnt_d   = 4'd0;
                  oe_d    = rw_q ? ~sr_q[7] : 1'b0;
                  state_d = rw_q ? StRdData : StWord1;
               end
            end
            StWord1Ack, StWord2Ack, StWrAck: begin
               if (scl_fall) begin
                  oe_d    = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = (state_q == StWord1Ack && bit_ctrl) ? StWord2 : StWrData;
               end
            end
            StRdData: begin
               if (scl_rise && !cnt_q[3]) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q[3]) begin
                     oe_d     = 1'b0;
                     ptr_d    = ptr_inc;
                     ack_ok_d = 1'b0;
                     state_d  = StRdAck;
                  end else begin
                     oe_d = ~sr_q[6];
                     sr_d = {sr_q[6:0], 1'b0};
                  end
               end
            end
            StRdAck: begin
               if (scl_rise) begin
                  if (!sda_v) begin
                     ack_ok_d = 1'b1;
                     re_d     = 1'b1;
                     addr_d   = ptr_q;
                  end else begin
                     state_d = StIdle;
                  end
               end else if (scl_fall && ack_ok_q) begin
                  cnt_d   = 4'd0;
                  oe_d    = ~sr_q[7];
                  state_d = StRdData;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         sr_q     <= 8'd0;
         hi_q     <= 8'd0;
         ptr_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= 8'd0;
         rw_q     <= 1'b0;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         ack_ok_q <= 1'b0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         stop_q   <= 1'b0;
         rd_cap_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         hi_q     <= hi_d;
         ptr_q    <= ptr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rw_q     <= rw_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         ack_ok_q <= ack_ok_d;
         we_q     <= we_d;
         re_q     <= re_d;
         stop_q   <= stop_d;
         rd_cap_q <= re_q;
      end
   end

   // Gate with reset so the line is freed as soon as reset is applied.
   assign sda       = (oe_q && !sys_rst) ? 1'b0 : 1'bz;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign mem_re    = re_q;
   assign busy      = busy_q;
   assign stop_det  = stop_q;

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: bus-level initiator tasks, a read-only memory model and
// write/read scoreboards compared after each transfer.
module tb_iic_target;

   localparam int H = 10;  // sys_clk cycles per scl half period

   logic        sys_clk = 1'b0;
   logic        sys_rst, bit_ctrl, scl, drv_low;
   wire         sda;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_we, mem_re, busy, stop_det;

   logic [7:0]  mem [0:65535];
   logic [23:0] exp_wr[$], obs_wr[$];
   logic [15:0] exp_rd[$], obs_rd[$];
   int          stop_cnt = 0;
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 sys_clk = ~sys_clk;

   assign sda = drv_low ? 1'b0 : 1'bz;
   pullup (sda);

   iic_target #(.DEVICE_ADDR(7'b1010000), .MEM_AW(16)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .bit_ctrl (bit_ctrl),
      .scl      (scl),
      .sda      (sda),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .stop_det (stop_det)
   );

   always @(posedge sys_clk) begin
      if (mem_we) obs_wr.push_back({mem_addr, mem_wdata});
      if (mem_re) begin
         obs_rd.push_back(mem_addr);
         mem_rdata <= mem[mem_addr];
      end
      if (stop_det) stop_cnt <= stop_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic i2c_start();
      drv_low = 1'b0;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      drv_low = 1'b1;
      wait_clk(H);
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic i2c_stop();
      drv_low = 1'b1;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      drv_low = 1'b0;
      wait_clk(H);
   endtask

   task automatic clock_pulse(output logic bit_seen);
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H / 2);
      bit_seen = (sda === 1'b1);
      wait_clk(H / 2);
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         drv_low = ~b[i];
         clock_pulse(s);
      end
      drv_low = 1'b0;
      clock_pulse(s);
      ack = ~s;
   endtask

   task automatic read_byte(output logic [7:0] b, input logic ack);
      logic s;
      drv_low = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         clock_pulse(s);
         b[i] = s;
      end
      drv_low = ack;
      clock_pulse(s);
      drv_low = 1'b0;
   endtask

   task automatic drain(input string tag);
      check({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
      while (obs_wr.size() > 0 && exp_wr.size() > 0)
         check({tag, "_wr"}, obs_wr.pop_front(), exp_wr.pop_front());
      check({tag, "_rd_count"}, obs_rd.size(), exp_rd.size());
      while (obs_rd.size() > 0 && exp_rd.size() > 0)
         check({tag, "_rd"}, obs_rd.pop_front(), exp_rd.pop_front());
      obs_wr.delete();
      exp_wr.delete();
      obs_rd.delete();
      exp_rd.delete();
   endtask

   initial begin
      logic       ack, s;
      logic [7:0] rb;
      int         s0;

      mem[16'h0000] = 8'hC3;
      mem[16'h0001] = 8'h00;
      mem[16'h0010] = 8'h5A;
      sys_rst  = 1'b1;
      bit_ctrl = 1'b0;
      scl      = 1'b1;
      drv_low  = 1'b0;
      wait_clk(5);
      check("rst_sda", sda, 1'b1);
      check("rst_we", mem_we, 1'b0);
      check("rst_re", mem_re, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_stop", stop_det, 1'b0);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_wdata", mem_wdata, 8'h00);
      sys_rst = 1'b0;
      wait_clk(5);

      // Write with two-byte word address
      bit_ctrl = 1'b1;
      i2c_start();
      send_byte(8'hA0, ack);
      check("wr_ack_dev", ack, 1'b1);
      check("wr_busy", busy, 1'b1);
      send_byte(8'h00, ack);
      check("wr_ack_w1", ack, 1'b1);
      send_byte(8'hA5, ack);
      check("wr_ack_w2", ack, 1'b1);
      exp_wr.push_back({16'h00A5, 8'h3C});
      send_byte(8'h3C, ack);
      check("wr_ack_data", ack, 1'b1);
      s0 = stop_cnt;
      i2c_stop();
      check("wr_stop_det", stop_cnt - s0, 1);
      check("wr_busy_end", busy, 1'b0);
      drain("wr2");

      // Address mismatch
      i2c_start();
      send_byte(8'hA2, ack);
      check("mis_nack", ack, 1'b0);
      check("mis_busy", busy, 1'b0);
      i2c_stop();
      drain("mis");

      // Random read via repeated START
      i2c_start();
      send_byte(8'hA0, ack);
      send_byte(8'h00, ack);
      send_byte(8'h10, ack);
      check("rr_ack_w2", ack, 1'b1);
      i2c_start();
      exp_rd.push_back(16'h0010);
      send_byte(8'hA1, ack);
      check("rr_ack_dev", ack, 1'b1);
      read_byte(rb, 1'b0);
      check("rr_data", rb, 8'h5A);
      check("rr_sda_rel", sda, 1'b1);
      i2c_stop();
      drain("rr");

      // Sequential write with 8-bit pointer wrap
      bit_ctrl = 1'b0;
      i2c_start();
      send_byte(8'hA0, ack);
      send_byte(8'hFE, ack);
      exp_wr.push_back({16'h00FE, 8'h11});
      exp_wr.push_back({16'h00FF, 8'h22});
      exp_wr.push_back({16'h0000, 8'h33});
      send_byte(8'h11, ack);
      send_byte(8'h22, ack);
      send_byte(8'h33, ack);
      check("wrap_ack_last", ack, 1'b1);
      i2c_stop();
      drain("wrap");

      // Reset during bit 3 of a current-address read (pointer now 0x0001, data 0x00)
      i2c_start();
      exp_rd.push_back(16'h0001);
      send_byte(8'hA1, ack);
      check("rrst_ack", ack, 1'b1);
      clock_pulse(s);
      clock_pulse(s);
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H / 2);
      check("rrst_sda_pre", sda, 1'b0);
      sys_rst = 1'b1;
      wait_clk(1);
      check("rrst_sda_rel", sda, 1'b1);
      check("rrst_busy", busy, 1'b0);
      sys_rst = 1'b0;
      wait_clk(H / 2);
      scl = 1'b0;
      wait_clk(2);
      for (int i = 0; i < 6; i++) begin
         clock_pulse(s);
         check("rrst_ignored", s, 1'b1);
      end
      check("rrst_busy_end", busy, 1'b0);
      drain("rrst");

      // Fresh transfer after reset reads from pointer 0
      i2c_start();
      exp_rd.push_back(16'h0000);
      send_byte(8'hA1, ack);
      check("post_ack", ack, 1'b1);
      read_byte(rb, 1'b0);
      check("post_data", rb, 8'hC3);
      i2c_stop();
      drain("post");

      // One-cycle low glitch on sda while scl is high
      wait_clk(H);
      s0 = stop_cnt;
      drv_low = 1'b1;
      wait_clk(1);
      drv_low = 1'b0;
      wait_clk(H);
`ifdef IIC_TGT_GLITCH_FILTER_EN
      check("glitch_stop", stop_cnt - s0, 0);
`else
      check("glitch_stop", stop_cnt - s0, 1);
`endif
      check("glitch_busy", busy, 1'b0);
      drain("glitch");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
